// File: rtl/cond_flags_unit.sv
// Condition-check and NZCV flag register for the ARM-style control path.
// Gates PC, register and memory writes on the condition passing against the registered flags.
module cond_flags_unit #(
   parameter logic [3:0] FLAG_RST = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       NoWrite,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       CondEx,
   output logic [3:0] Flags
);

   logic n, z, c, v;

   assign {n, z, c, v} = Flags;

   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         4'b0000: CondEx = z;
         4'b0001: CondEx = ~z;
         4'b0010: CondEx = c;
         4'b0011: CondEx = ~c;
         4'b0100: CondEx = n;
         4'b0101: CondEx = ~n;
         4'b0110: CondEx = v;
         4'b0111: CondEx = ~v;
         4'b1000: CondEx = c & ~z;
         4'b1001: CondEx = ~c | z;
         4'b1010: CondEx = ~(n ^ v);
         4'b1011: CondEx = n ^ v;
         4'b1100: CondEx = ~z & ~(n ^ v);
         4'b1101: CondEx = z | (n ^ v);
         4'b1110: CondEx = 1'b1;
         4'b1111: CondEx = 1'b0;
      endcase
   end

   // CondEx here is derived from the pre-edge Flags, so a flag setter is gated by the old flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Flags <= FLAG_RST;
      end else begin
         if (FlagW[1] && CondEx) Flags[3:2] <= ALUFlags[3:2];
         if (FlagW[0] && CondEx) Flags[1:0] <= ALUFlags[1:0];
      end
   end

   assign PCSrc    = PCS & CondEx;
   assign MemWrite = MemW & CondEx;
   assign RegWrite = RegW & CondEx & ~NoWrite;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Self-checking bench for cond_flags_unit: directed scenarios plus randomized
// instruction streams checked against a behavioural flag/condition model.
module tb_cond_flags_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS, RegW, MemW, NoWrite;
   logic       PCSrc, RegWrite, MemWrite, CondEx;
   logic [3:0] Flags;

   int checks = 0;
   int errors = 0;
   logic [3:0] model_flags;

   cond_flags_unit #(.FLAG_RST(4'b0000)) dut (
      .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
      .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
      .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .CondEx(CondEx), .Flags(Flags)
   );

   always #5 clk = ~clk;

   // Condition table in mnemonic terms: signed compares via N==V, unsigned via C/Z.
   function automatic logic ref_pass(input logic [3:0] cond, input logic [3:0] f);
      bit nf, zf, cf, vf, ge, hi;
      nf = f[3]; zf = f[2]; cf = f[1]; vf = f[0];
      ge = (nf == vf);
      hi = (cf == 1'b1) && (zf == 1'b0);
      case (cond)
         0:  return zf;
         1:  return !zf;
         2:  return cf;
         3:  return !cf;
         4:  return nf;
         5:  return !nf;
         6:  return vf;
         7:  return !vf;
         8:  return hi;
         9:  return !hi;
         10: return ge;
         11: return !ge;
         12: return ge && !zf;
         13: return !(ge && !zf);
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic idle_inputs();
      Cond = 4'b1110; ALUFlags = '0; FlagW = '0;
      PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
   endtask

   // Loads a known flag value through an unconditional flag-setting instruction.
   task automatic set_flags(input logic [3:0] val);
      @(negedge clk);
      idle_inputs();
      FlagW = 2'b11; ALUFlags = val;
      @(posedge clk);
      #1;
      FlagW = 2'b00;
      model_flags = val;
   endtask

   task automatic test_reset();
      checks++;
      if (Flags !== 4'b0000) begin errors++; $display("FAIL reset_initial Flags got %b want 0000", Flags); end
      @(negedge clk);
      reset = 0;
      set_flags(4'b1111);
      @(negedge clk);
      #2;
      reset = 1;
      #1;
      checks++;
      if (Flags !== 4'b0000) begin errors++; $display("FAIL reset_async Flags got %b want 0000", Flags); end
      Cond = 4'b0000; PCS = 1; #1;
      checks++;
      if (CondEx !== 1'b0 || PCSrc !== 1'b0) begin errors++; $display("FAIL reset_eq CondEx/PCSrc got %b%b want 00", CondEx, PCSrc); end
      Cond = 4'b0001; #1;
      checks++;
      if (CondEx !== 1'b1 || PCSrc !== 1'b1) begin errors++; $display("FAIL reset_ne CondEx/PCSrc got %b%b want 11", CondEx, PCSrc); end
      Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
      @(posedge clk); #1;
      checks++;
      if (Flags !== 4'b0000) begin errors++; $display("FAIL reset_hold Flags got %b want 0000", Flags); end
      @(negedge clk);
      reset = 0;
      idle_inputs();
      model_flags = 4'b0000;
   endtask

   task automatic test_cmp_branch();
      set_flags(4'b0000);
      @(negedge clk);
      idle_inputs();
      Cond = 4'b1110; FlagW = 2'b11; NoWrite = 1; RegW = 1; ALUFlags = 4'b0100;
      #1;
      checks++;
      if (RegWrite !== 1'b0) begin errors++; $display("FAIL cmp_regwrite got %b want 0", RegWrite); end
      checks++;
      if (Flags !== 4'b0000) begin errors++; $display("FAIL cmp_no_bypass Flags got %b want 0000", Flags); end
      @(negedge clk);
      idle_inputs();
      Cond = 4'b0000; PCS = 1;
      #1;
      checks++;
      if (Flags !== 4'b0100 || CondEx !== 1'b1 || PCSrc !== 1'b1) begin
         errors++; $display("FAIL cmp_branch Flags/CondEx/PCSrc got %b/%b/%b want 0100/1/1", Flags, CondEx, PCSrc);
      end
      idle_inputs();
      model_flags = 4'b0100;
   endtask

   task automatic test_partial();
      set_flags(4'b0000);
      @(negedge clk);
      FlagW = 2'b10; ALUFlags = 4'b1011; Cond = 4'b1110;
      @(posedge clk); #1;
      checks++;
      if (Flags !== 4'b1000) begin errors++; $display("FAIL partial_nz Flags got %b want 1000", Flags); end
      set_flags(4'b0000);
      @(negedge clk);
      FlagW = 2'b01; ALUFlags = 4'b1011; Cond = 4'b1110;
      @(posedge clk); #1;
      checks++;
      if (Flags !== 4'b0011) begin errors++; $display("FAIL partial_cv Flags got %b want 0011", Flags); end
      idle_inputs();
      model_flags = 4'b0011;
   endtask

   task automatic test_suppress();
      set_flags(4'b0100);
      @(negedge clk);
      idle_inputs();
      Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b1111; MemW = 1;
      #1;
      checks++;
      if (CondEx !== 1'b0 || MemWrite !== 1'b0) begin errors++; $display("FAIL suppress_comb CondEx/MemWrite got %b%b want 00", CondEx, MemWrite); end
      @(posedge clk); #1;
      checks++;
      if (Flags !== 4'b0100) begin errors++; $display("FAIL suppress_flags got %b want 0100", Flags); end
      idle_inputs();
      model_flags = 4'b0100;
   endtask

   task automatic test_cond_table();
      for (int f = 0; f < 16; f++) begin
         set_flags(f[3:0]);
         checks++;
         if (Flags !== f[3:0]) begin errors++; $display("FAIL table_load Flags got %b want %b", Flags, f[3:0]); end
         for (int c = 0; c < 16; c++) begin
            Cond = c[3:0];
            #1;
            checks++;
            if (CondEx !== ref_pass(c[3:0], f[3:0])) begin
               errors++; $display("FAIL cond_table flags=%b cond=%b CondEx got %b want %b", f[3:0], c[3:0], CondEx, ref_pass(c[3:0], f[3:0]));
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_random();
      logic exp_ex;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         Cond = 4'($urandom_range(0, 15));
         ALUFlags = 4'($urandom_range(0, 15));
         FlagW = 2'($urandom_range(0, 3));
         PCS = 1'($urandom_range(0, 1));
         RegW = 1'($urandom_range(0, 1));
         MemW = 1'($urandom_range(0, 1));
         NoWrite = 1'($urandom_range(0, 1));
         #1;
         exp_ex = ref_pass(Cond, model_flags);
         checks++;
         if (CondEx !== exp_ex || PCSrc !== (PCS && exp_ex) || MemWrite !== (MemW && exp_ex)
             || RegWrite !== (RegW && exp_ex && !NoWrite)) begin
            errors++;
            $display("FAIL random_outputs it=%0d got CondEx/PCSrc/MemWrite/RegWrite %b%b%b%b want %b%b%b%b",
                     i, CondEx, PCSrc, MemWrite, RegWrite, exp_ex, PCS && exp_ex, MemW && exp_ex, RegW && exp_ex && !NoWrite);
         end
         if (exp_ex && FlagW[1]) model_flags[3:2] = ALUFlags[3:2];
         if (exp_ex && FlagW[0]) model_flags[1:0] = ALUFlags[1:0];
         @(posedge clk); #1;
         checks++;
         if (Flags !== model_flags) begin errors++; $display("FAIL random_flags it=%0d got %b want %b", i, Flags, model_flags); end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      set_flags(4'b0000);
      @(negedge clk);
      FlagW = 2'b11; ALUFlags = 4'b1111; Cond = 4'b1110;
      #3;
      reset = 1;
      @(posedge clk);
      #2;
      reset = 0;
      #1;
      checks++;
      if (Flags !== 4'b0000) begin errors++; $display("FAIL reset_mid_discard Flags got %b want 0000", Flags); end
      @(posedge clk); #1;
      checks++;
      if (Flags !== 4'b1111) begin errors++; $display("FAIL reset_mid_first_update Flags got %b want 1111", Flags); end
      idle_inputs();
      model_flags = 4'b1111;
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      model_flags = 4'b0000;
      #1;
      test_reset();
      test_cmp_branch();
      test_partial();
      test_suppress();
      test_cond_table();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cond_flags_unit.md
COND_FLAGS_UNIT -- requirements
Module: cond_flags_unit

Interface
REQ-001 SHALL have parameter FLAG_RST, default 4'b0000, meaning the NZCV value loaded on reset.
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Cond  input  4  instruction condition field [31:28].
REQ-005 SHALL have port ALUFlags  input  4  ALU result flags {N,Z,C,V} from the ALU flag generators.
REQ-006 SHALL have port FlagW  input  2  flag-write request; bit1 updates N,Z and bit0 updates C,V.
REQ-007 SHALL have port PCS, RegW, MemW  input  1 each  unconditioned PC-write, register-write and memory-write requests from the decoder.
REQ-008 SHALL have port NoWrite  input  1  compare-class instruction (CMP/CMN/TST/TEQ); suppresses register write.
REQ-009 SHALL have port PCSrc, RegWrite, MemWrite  output  1 each  condition-gated write enables.
REQ-010 SHALL have port CondEx  output  1  the current instruction's condition passes.
REQ-011 SHALL have port Flags  output  4  registered {N,Z,C,V} state.

Function
REQ-012 SHALL hold N,Z,C,V in a 4-bit register driven to Flags, updated only on the rising edge of clk.
REQ-013 SHALL compute CondEx combinationally from Cond and the registered Flags (not ALUFlags), decoded as follows.
REQ-014 SHALL decode Cond: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
REQ-015 SHALL decode Cond: 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0 (reserved, never executes).
REQ-016 SHALL, at a rising edge with FlagW[1]&CondEx, load Flags[3:2] from ALUFlags[3:2]; otherwise hold them.
REQ-017 SHALL, at a rising edge with FlagW[0]&CondEx, load Flags[1:0] from ALUFlags[1:0]; otherwise hold them.
REQ-018 SHALL evaluate CondEx for the flag-update decision with the pre-edge Flags value, so that a flag-setting instruction is conditioned on the old flags, not its own result.
REQ-019 SHALL drive PCSrc = PCS & CondEx, MemWrite = MemW & CondEx, RegWrite = RegW & CondEx & !NoWrite, all combinational with zero latency.
REQ-020 SHALL make new flags visible on Flags and in CondEx exactly one cycle after the writing instruction, with no bypass from ALUFlags.
REQ-021 SHALL treat FlagW = 2'b11 as a simultaneous update of all four flags in one edge, and FlagW = 2'b00 as no update regardless of CondEx.
REQ-022 SHALL leave Flags unchanged when CondEx = 0, even if FlagW is nonzero.
REQ-023 SHALL produce no X on any output when all inputs are known; the Cond 1111 case SHALL be covered explicitly, not via X-default.

Reset
REQ-024 SHALL, while reset is high, force Flags to FLAG_RST immediately (asynchronously) and hold it regardless of clk.
REQ-025 SHALL, on a reset asserted mid-operation, discard any pending flag update of that cycle; the first update SHALL occur at the first rising edge after reset deasserts.
REQ-026 SHALL keep outputs PCSrc, RegWrite, MemWrite and CondEx combinational during reset, evaluated against Flags = FLAG_RST (with default 0000: EQ fails, NE passes, AL passes).

Verification
REQ-027 SHALL verify reset: assert reset between edges with Flags = 1111 -> Flags = 0000 before the next edge; Cond = 0000 -> CondEx = 0; Cond = 0001 -> CondEx = 1.
REQ-028 SHALL verify CMP-then-branch: cycle 1 Cond = 1110, FlagW = 11, NoWrite = 1, RegW = 1, ALUFlags = 0100 -> RegWrite = 0; cycle 2 Cond = 0000, PCS = 1 -> Flags = 0100, CondEx = 1, PCSrc = 1.
REQ-029 SHALL verify partial update: Flags = 0000, FlagW = 10, ALUFlags = 1011, Cond = 1110 -> after one edge Flags = 1000 (C and V retained at 0).
REQ-030 SHALL verify suppression: Flags = 0100, Cond = 0001 (NE), FlagW = 11, ALUFlags = 1111, MemW = 1 -> CondEx = 0, MemWrite = 0, and Flags stays 0100 after the edge.
REQ-031 SHALL verify signed conditions exhaustively: all 16 Flags values x all 16 Cond values -> CondEx matches the REQ-014/015 table (e.g. Flags = 1001 gives GE = 1, LT = 0, GT = 1; Flags = 1000 gives LT = 1, LE = 1).
REQ-032 SHALL verify reset mid-update: FlagW = 11, ALUFlags = 1111, Cond = 1110, and reset pulsed across the edge -> Flags = 0000 after reset deasserts and Flags = 1111 only after the next edge.
